// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control path:
// sequencer state encoding and the NOP control bus loaded on a bubble.
package mips_pkg;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_DBG_WAIT = 2'd1;
   localparam logic [1:0] ST_DRAIN    = 2'd2;
   localparam logic [1:0] ST_HALTED   = 2'd3;

   typedef enum logic [1:0] {
      RUN      = ST_RUN,
      DBG_WAIT = ST_DBG_WAIT,
      DRAIN    = ST_DRAIN,
      HALTED   = ST_HALTED
   } state_t;

   localparam logic [8:0] NOP_EX  = 9'b0;
   localparam logic [7:0] NOP_MEM = 8'b0;
   localparam logic [1:0] NOP_WB  = 2'b0;

   typedef struct packed {
      logic [8:0] ex;
      logic [7:0] mem;
      logic [1:0] wb;
   } ctrl_bus_t;

   localparam ctrl_bus_t NOP_CTRL = '{ex: NOP_EX, mem: NOP_MEM, wb: NOP_WB};

   // ID/EX control input: decoded bus, or all-zero NOP when bubbling
   function automatic ctrl_bus_t bubble_mux(input logic bubble,
                                            input ctrl_bus_t ctrl);
      return bubble ? NOP_CTRL : ctrl;
   endfunction

endpackage

// File: rtl/load_use_detector.sv
// Flags an IF/ID instruction reading the register a load in ID/EX
// is about to write; r0 never creates a hazard.
module load_use_detector #(
   parameter int NB = 5
) (
   input  logic          mem_read,
   input  logic [NB-1:0] rt_ex,
   input  logic [NB-1:0] rs_id,
   input  logic [NB-1:0] rt_id,
   output logic          load_use
);

   assign load_use = mem_read
                   & (rt_ex != '0)
                   & ((rt_ex == rs_id) | (rt_ex == rt_id));

endmodule

// File: rtl/pipeline_control.sv
// Stall/flush/halt sequencer with debug single-step for the 5-stage pipe.
// Define PIPE_CTRL_PERF_EN to build the cycle and stall counters.
module pipeline_control
   import mips_pkg::*;
#(
   parameter int len          = 32,
   parameter int NB           = $clog2(len),
   parameter int DRAIN_CYCLES = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_mem_read_2_3,
   input  logic [NB-1:0]  in_rt_2_3,
   input  logic [NB-1:0]  in_rs_1_2,
   input  logic [NB-1:0]  in_rt_1_2,
   input  logic           in_branch_taken,
   input  logic           in_halt,
   input  logic           in_debug_mode,
   input  logic           in_step,
   output logic           pc_enable,
   output logic           if_id_enable,
   output logic           id_ex_bubble,
   output logic           flush_if_id,
   output logic           flush_id_ex,
   output logic           flush_ex_mem,
   output logic           halted,
   output logic [len-1:0] cycle_count,
   output logic [len-1:0] stall_count
);

   localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

   state_t        state, state_n;
   logic [DW-1:0] drain_cnt, drain_n;
   logic          step_q;
   logic          step_pulse;
   logic          run_rules;
   logic          load_use;

   load_use_detector #(.NB(NB)) u_lud (
      .mem_read (in_mem_read_2_3),
      .rt_ex    (in_rt_2_3),
      .rs_id    (in_rs_1_2),
      .rt_id    (in_rt_1_2),
      .load_use (load_use)
   );

   assign step_pulse = in_step & ~step_q;
   // a single-step request lets DBG_WAIT behave like RUN for one cycle
   assign run_rules  = (state == RUN)
                     | ((state == DBG_WAIT) & step_pulse);

   always_comb begin
      state_n      = state;
      drain_n      = drain_cnt;
      pc_enable    = 1'b1;
      if_id_enable = 1'b1;
      id_ex_bubble = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      unique case (state)
         RUN, DBG_WAIT: begin
            if (state == DBG_WAIT && !in_debug_mode)
               state_n = RUN;
            if (!run_rules) begin
               pc_enable    = 1'b0;
               if_id_enable = 1'b0;
            end else if (in_branch_taken) begin
               flush_if_id  = 1'b1;
               flush_id_ex  = 1'b1;
               flush_ex_mem = 1'b1;
            end else if (load_use) begin
               pc_enable    = 1'b0;
               if_id_enable = 1'b0;
               id_ex_bubble = 1'b1;
            end else if (in_halt) begin
               pc_enable    = 1'b0;
               if_id_enable = 1'b0;
               drain_n      = DRAIN_LOAD;
               state_n      = DRAIN;
            end else if (state == RUN && in_debug_mode && !step_pulse) begin
               pc_enable    = 1'b0;
               if_id_enable = 1'b0;
               state_n      = DBG_WAIT;
            end
         end
         DRAIN: begin
            if (in_branch_taken) begin
               flush_if_id  = 1'b1;
               flush_id_ex  = 1'b1;
               flush_ex_mem = 1'b1;
               state_n      = RUN;
            end else begin
               pc_enable    = 1'b0;
               if_id_enable = 1'b0;
               id_ex_bubble = 1'b1;
               if (drain_cnt == '0)
                  state_n = HALTED;
               else
                  drain_n = drain_cnt - 1'b1;
            end
         end
         HALTED: begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_bubble = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         drain_cnt <= '0;
         step_q    <= 1'b0;
         halted    <= 1'b0;
      end else begin
         state     <= state_n;
         drain_cnt <= drain_n;
         step_q    <= in_step;
         halted    <= (state_n == HALTED);
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic           stall_hit;
   logic           cyc_hit;
   logic [len-1:0] cyc_q;
   logic [len-1:0] stall_q;

   assign stall_hit = run_rules & ~in_branch_taken & load_use;
   assign cyc_hit   = run_rules | (state == DRAIN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_q   <= '0;
         stall_q <= '0;
      end else begin
         if (cyc_hit)
            cyc_q <= cyc_q + len'(1);
         if (stall_hit)
            stall_q <= stall_q + len'(1);
      end
   end

   assign cycle_count = cyc_q;
   assign stall_count = stall_q;
`else
   assign cycle_count = '0;
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Randomized and directed bench for pipeline_control against a
// cycle-level behavioural model of the sequencer rules.
module tb_pipeline_control;

   localparam int LEN = 32;
   localparam int NB  = 5;
`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic           in_mem_read_2_3;
   logic [NB-1:0]  in_rt_2_3;
   logic [NB-1:0]  in_rs_1_2;
   logic [NB-1:0]  in_rt_1_2;
   logic           in_branch_taken;
   logic           in_halt;
   logic           in_debug_mode;
   logic           in_step;
   logic           pc_enable;
   logic           if_id_enable;
   logic           id_ex_bubble;
   logic           flush_if_id;
   logic           flush_id_ex;
   logic           flush_ex_mem;
   logic           halted;
   logic [LEN-1:0] cycle_count;
   logic [LEN-1:0] stall_count;

   pipeline_control #(.len(LEN), .NB(NB), .DRAIN_CYCLES(3)) dut (
      .clk             (clk),
      .reset           (reset),
      .in_mem_read_2_3 (in_mem_read_2_3),
      .in_rt_2_3       (in_rt_2_3),
      .in_rs_1_2       (in_rs_1_2),
      .in_rt_1_2       (in_rt_1_2),
      .in_branch_taken (in_branch_taken),
      .in_halt         (in_halt),
      .in_debug_mode   (in_debug_mode),
      .in_step         (in_step),
      .pc_enable       (pc_enable),
      .if_id_enable    (if_id_enable),
      .id_ex_bubble    (id_ex_bubble),
      .flush_if_id     (flush_if_id),
      .flush_id_ex     (flush_id_ex),
      .flush_ex_mem    (flush_ex_mem),
      .halted          (halted),
      .cycle_count     (cycle_count),
      .stall_count     (stall_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // model: remaining drain cycles, halted flag, in-debug flag, step history
   int          m_drain;
   bit          m_halted;
   bit          m_dbg;
   bit          m_prev_step;
   int unsigned m_cyc;
   int unsigned m_stall;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned cnt_exp(input int unsigned v);
      return PERF ? v : 0;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset           = 1'b1;
      in_mem_read_2_3 = 1'b0;
      in_rt_2_3       = '0;
      in_rs_1_2       = '0;
      in_rt_1_2       = '0;
      in_branch_taken = 1'b0;
      in_halt         = 1'b0;
      in_debug_mode   = 1'b0;
      in_step         = 1'b0;
      #1;
      m_drain = 0; m_halted = 0; m_dbg = 0; m_prev_step = 0;
      m_cyc = 0; m_stall = 0;
      chk("rst_pc_en", pc_enable, 1);
      chk("rst_ifid_en", if_id_enable, 1);
      chk("rst_flush", {id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem}, 0);
      chk("rst_halted", halted, 0);
      chk("rst_cycle", cycle_count, 0);
      chk("rst_stall", stall_count, 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic cyc(input bit mr, input int rt2, input int rs1, input int rt1,
                      input bit br, input bit hlt, input bit dbg, input bit stp);
      bit lu, pulse;
      bit e_pc, e_ifid, e_bub, e_fl;
      int n_drain;
      bit n_halted, n_dbg;
      int unsigned n_cyc, n_stall;
      @(negedge clk);
      in_mem_read_2_3 = mr;
      in_rt_2_3       = NB'(rt2);
      in_rs_1_2       = NB'(rs1);
      in_rt_1_2       = NB'(rt1);
      in_branch_taken = br;
      in_halt         = hlt;
      in_debug_mode   = dbg;
      in_step         = stp;
      #1;
      lu    = mr && rt2 != 0 && (rt2 == rs1 || rt2 == rt1);
      pulse = stp && !m_prev_step;
      e_pc = 1; e_ifid = 1; e_bub = 0; e_fl = 0;
      n_drain = m_drain; n_halted = m_halted; n_dbg = m_dbg;
      n_cyc = m_cyc; n_stall = m_stall;
      if (m_halted) begin
         e_pc = 0; e_ifid = 0; e_bub = 1;
      end else if (m_drain > 0) begin
         n_cyc++;
         if (br) begin
            e_fl = 1; n_drain = 0;
         end else begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
            n_drain = m_drain - 1;
            if (n_drain == 0) n_halted = 1;
         end
      end else if (m_dbg && !pulse) begin
         e_pc = 0; e_ifid = 0;
         if (!dbg) n_dbg = 0;
      end else begin
         n_cyc++;
         if (m_dbg && !dbg) n_dbg = 0;
         if (br) e_fl = 1;
         else if (lu) begin
            e_pc = 0; e_ifid = 0; e_bub = 1; n_stall++;
         end else if (hlt) begin
            e_pc = 0; e_ifid = 0; n_drain = 3; n_dbg = 0;
         end else if (!m_dbg && dbg && !pulse) begin
            e_pc = 0; e_ifid = 0; n_dbg = 1;
         end
      end
      chk("pc_enable", pc_enable, e_pc);
      chk("if_id_enable", if_id_enable, e_ifid);
      chk("id_ex_bubble", id_ex_bubble, e_bub);
      chk("flush_if_id", flush_if_id, e_fl);
      chk("flush_id_ex", flush_id_ex, e_fl);
      chk("flush_ex_mem", flush_ex_mem, e_fl);
      @(posedge clk);
      m_drain = n_drain; m_halted = n_halted; m_dbg = n_dbg;
      m_prev_step = stp; m_cyc = n_cyc; m_stall = n_stall;
      #1;
      chk("halted", halted, m_halted);
      chk("cycle_count", cycle_count, cnt_exp(m_cyc));
      chk("stall_count", stall_count, cnt_exp(m_stall));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bit r_dbg;
      reset = 1'b1;
      do_reset();

      // load r5, IF/ID rs=5: one stall cycle
      cyc(1, 5, 5, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("lu_stall_lit", stall_count, PERF ? 1 : 0);
      // load into r0: no stall
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("r0_stall_lit", stall_count, PERF ? 1 : 0);
      // branch beats load-use
      cyc(1, 5, 0, 5, 1, 0, 0, 0);
      chk("br_stall_lit", stall_count, PERF ? 1 : 0);

      // halt: 3 drain cycles then halted, held 10 cycles
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      idle(3);
      chk("halt_lit", halted, 1);
      idle(10);
      chk("halt_hold_lit", halted, 1);
      do_reset();

      // halt cancelled by branch in 2nd drain cycle
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      idle(1);
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      idle(6);
      chk("halt_cancel_lit", halted, 0);

      // debug: step held 5 cycles, then two toggles
      do_reset();
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      idle(0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 1, 1);
      chk("step_hold_lit", cycle_count, PERF ? 2 : 0);
      for (int i = 0; i < 2; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 1, 0);
         cyc(0, 0, 0, 0, 0, 0, 1, 1);
      end
      chk("step_tog_lit", cycle_count, PERF ? 4 : 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);

      // randomized traffic with periodic resets
      for (int r = 0; r < 8; r++) begin
         do_reset();
         r_dbg = 0;
         for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 19) == 0) r_dbg = ~r_dbg;
            cyc($urandom_range(0, 2) == 0,
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 29) == 0,
                r_dbg,
                $urandom_range(0, 2) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
